// File: rtl/energy_pkg.sv
// energy_pkg: shared types and width helper for the energy accumulator.
//   energy_state_e : IDLE -> ACCUM -> DONE evaluation sequence
//   energy_width   : default accumulator width for a given vector size / J width
package energy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } energy_state_e;

    // Dot width is (jw+1)+log2(vs); the sum of vs spin-weighted dots needs
    // another log2(vs) bits, plus one so the most negative dot can be negated.
    function automatic int unsigned energy_width(int unsigned vs, int unsigned jw);
        return (jw + 1) + 2 * $clog2(vs) + 1;
    endfunction

endpackage

// File: rtl/energy_accumulator.sv
// energy_accumulator: folds VECTOR_SIZE column dot products into one signed
// Ising energy, weighting each column by the +/-1 spin latched at start.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   start_i, sigma     : begin an evaluation and latch the spin vector
//   clear_i            : synchronous abort back to IDLE
//   dot_valid_i, dot_i : next column's signed dot product
//   busy_o             : evaluation in progress (ACCUM or DONE)
//   col_idx_o          : index of the next expected column
//   energy_valid_o     : one-cycle pulse when energy_o is updated
//   energy_o           : last completed energy
//   err_o              : sticky, dot arrived outside ACCUM
module energy_accumulator
    import energy_pkg::*;
#(
    parameter int unsigned VECTOR_SIZE     = 256,
    parameter int unsigned J_ELEMENT_WIDTH = 4,
    parameter int unsigned DOT_WIDTH       = (J_ELEMENT_WIDTH + 1) + $clog2(VECTOR_SIZE),
    parameter int unsigned ENERGY_WIDTH    = energy_width(VECTOR_SIZE, J_ELEMENT_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic                           clear_i,
    input  logic [VECTOR_SIZE-1:0]         sigma,
    input  logic                           dot_valid_i,
    input  logic signed [DOT_WIDTH-1:0]    dot_i,
    output logic                           busy_o,
    output logic [$clog2(VECTOR_SIZE)-1:0] col_idx_o,
    output logic                           energy_valid_o,
    output logic signed [ENERGY_WIDTH-1:0] energy_o,
    output logic                           err_o
);

    localparam int unsigned CNT_W = $clog2(VECTOR_SIZE);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(VECTOR_SIZE - 1);

    energy_state_e                  state;
    logic [VECTOR_SIZE-1:0]         sigma_q;
    logic signed [ENERGY_WIDTH-1:0] acc;
    logic signed [ENERGY_WIDTH-1:0] dot_ext;
    logic signed [ENERGY_WIDTH-1:0] acc_sum;

    // Spin-weighted add; sign-extend first so negating the most negative dot is exact.
    always_comb begin
        dot_ext = ENERGY_WIDTH'(dot_i);
        acc_sum = sigma_q[col_idx_o] ? (acc + dot_ext) : (acc - dot_ext);
    end

    // col_idx_o is the column counter itself; it wraps to 0 as the last column lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            sigma_q        <= '0;
            acc            <= '0;
            col_idx_o      <= '0;
            busy_o         <= 1'b0;
            energy_valid_o <= 1'b0;
            energy_o       <= '0;
            err_o          <= 1'b0;
        end else begin
            energy_valid_o <= 1'b0;
            if (clear_i) begin
                state     <= IDLE;
                col_idx_o <= '0;
                busy_o    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            sigma_q   <= sigma;
                            acc       <= '0;
                            col_idx_o <= '0;
                            err_o     <= 1'b0;
                            busy_o    <= 1'b1;
                            state     <= ACCUM;
                        end else if (dot_valid_i) begin
                            err_o <= 1'b1;
                        end
                    end
                    ACCUM: begin
                        if (dot_valid_i) begin
                            acc       <= acc_sum;
                            col_idx_o <= col_idx_o + CNT_W'(1);
                            // Publish together with the pulse so valid and data coincide.
                            if (col_idx_o == LAST_COL) begin
                                energy_o       <= acc_sum;
                                energy_valid_o <= 1'b1;
                                state          <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (dot_valid_i) begin
                            err_o <= 1'b1;
                        end
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_energy_accumulator.sv
module tb_energy_accumulator;

    localparam int VS = 4;
    localparam int DW = 5;
    localparam int EW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start_i = 1'b0;
    logic                 clear_i = 1'b0;
    logic [VS-1:0]        sigma = '0;
    logic                 dot_valid_i = 1'b0;
    logic signed [DW-1:0] dot_i = '0;
    logic                 busy_o;
    logic [1:0]           col_idx_o;
    logic                 energy_valid_o;
    logic signed [EW-1:0] energy_o;
    logic                 err_o;

    int total = 0;
    int bad = 0;

    energy_accumulator #(.VECTOR_SIZE(VS), .J_ELEMENT_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i), .sigma(sigma),
        .dot_valid_i(dot_valid_i), .dot_i(dot_i), .busy_o(busy_o), .col_idx_o(col_idx_o),
        .energy_valid_o(energy_valid_o), .energy_o(energy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: collect the dots of a run, sum them with
    // their spin signs once all have arrived.
    int        m_phase = 0;   // 0 idle, 1 collecting dots, 2 result cycle
    int        m_dots[$];
    logic [VS-1:0] m_sig = '0;
    int        m_energy = 0;
    bit        m_valid = 0;
    bit        m_err = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_dots.delete(); m_sig = '0;
            m_energy = 0; m_valid = 0; m_err = 0;
        end else begin
            m_valid = 0;
            if (clear_i) begin
                m_phase = 0;
                m_dots.delete();
            end else if (m_phase == 0) begin
                if (start_i) begin
                    m_sig = sigma; m_dots.delete(); m_err = 0; m_phase = 1;
                end else if (dot_valid_i) begin
                    m_err = 1;
                end
            end else if (m_phase == 1) begin
                if (dot_valid_i) begin
                    m_dots.push_back(int'(dot_i));
                    if (m_dots.size() == VS) begin
                        m_energy = 0;
                        foreach (m_dots[i]) m_energy += m_sig[i] ? m_dots[i] : -m_dots[i];
                        m_valid = 1;
                        m_phase = 2;
                        m_dots.delete();
                    end
                end
            end else begin
                if (dot_valid_i) m_err = 1;
                m_phase = 0;
            end
        end
    end

    // Every-cycle comparison against the reference, away from the active edge.
    always @(negedge clk) begin
        check("busy", int'(busy_o), (m_phase != 0) ? 1 : 0);
        check("col_idx", int'(col_idx_o), m_dots.size() % VS);
        check("valid", int'(energy_valid_o), int'(m_valid));
        check("energy", int'(energy_o), m_energy);
        check("err", int'(err_o), int'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [VS-1:0] sig, input bit dot_too);
        sigma = sig; start_i = 1'b1; dot_valid_i = dot_too; dot_i = 5'sd7;
        tick();
        start_i = 1'b0; dot_valid_i = 1'b0; sigma = '0;
        check("busy_after_start", int'(busy_o), 1);
        check("err_after_start", int'(err_o), 0);
    endtask

    task automatic feed(input int d, input int gap, input bit poke, input int idx);
        for (int g = 0; g < gap; g++) begin
            if (poke) begin start_i = 1'b1; sigma = 4'b1010; end
            tick();
            start_i = 1'b0; sigma = '0;
        end
        check("col_step", int'(col_idx_o), idx);
        dot_valid_i = 1'b1; dot_i = DW'(d);
        tick();
        dot_valid_i = 1'b0;
    endtask

    task automatic run_eval(input string nm, input logic [VS-1:0] sig, input int d0, input int d1,
                            input int d2, input int d3, input bit gapped, input bit dot_too,
                            input int exp_e);
        int d[4];
        int gaps[4];
        d = '{d0, d1, d2, d3};
        gaps = gapped ? '{0, 1, 3, 2} : '{0, 0, 0, 0};
        begin_run(sig, dot_too);
        for (int i = 0; i < VS; i++) feed(d[i], gaps[i], gapped && (i == 2), i);
        check({nm, "_valid"}, int'(energy_valid_o), 1);
        check({nm, "_energy"}, int'(energy_o), exp_e);
        check({nm, "_model"}, m_energy, exp_e);
        check({nm, "_busy_done"}, int'(busy_o), 1);
        tick();
        check({nm, "_valid_off"}, int'(energy_valid_o), 0);
        check({nm, "_busy_off"}, int'(busy_o), 0);
        check({nm, "_hold"}, int'(energy_o), exp_e);
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", int'(busy_o), 0);
        check("rst_energy", int'(energy_o), 0);
        check("rst_err", int'(err_o), 0);
        rst = 1'b0;
        tick();

        run_eval("allpos", 4'b1111, 3, -2, 5, 1, 0, 0, 7);
        run_eval("mixed", 4'b0101, 3, -2, 5, 1, 0, 0, 9);
        run_eval("ext_pos", 4'b0000, -16, -16, -16, -16, 0, 0, 64);
        run_eval("ext_neg", 4'b1111, -16, -16, -16, -16, 0, 0, -64);
        run_eval("gapped", 4'b0101, 3, -2, 5, 1, 1, 0, 9);

        // Abort after two dots, then a stray dot in IDLE.
        begin_run(4'b1111, 0);
        feed(10, 0, 0, 0);
        feed(11, 0, 0, 1);
        clear_i = 1'b1; dot_valid_i = 1'b1; dot_i = 5'sd4;
        tick();
        clear_i = 1'b0; dot_valid_i = 1'b0;
        check("abort_busy", int'(busy_o), 0);
        check("abort_col", int'(col_idx_o), 0);
        check("abort_energy", int'(energy_o), 9);
        check("abort_err", int'(err_o), 0);
        repeat (2) tick();
        dot_valid_i = 1'b1; dot_i = 5'sd2;
        tick();
        dot_valid_i = 1'b0;
        check("stray_err", int'(err_o), 1);
        tick();
        check("stray_sticky", int'(err_o), 1);
        run_eval("after_err", 4'b1111, 3, -2, 5, 1, 0, 1, 7);

        // Reset in the middle of a run.
        begin_run(4'b1111, 0);
        feed(3, 0, 0, 0);
        feed(-2, 0, 0, 1);
        feed(5, 0, 0, 2);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_col", int'(col_idx_o), 0);
        check("midrst_valid", int'(energy_valid_o), 0);
        check("midrst_energy", int'(energy_o), 0);
        check("midrst_err", int'(err_o), 0);
        tick();
        rst = 1'b0;
        tick();
        run_eval("post_rst", 4'b1111, 3, -2, 5, 1, 0, 0, 7);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
